// File: rtl/cpu_pkg.sv
// Shared CPU types: branch kinds, LEGv8 condition codes and the NZCV flag bundle.
package cpu_pkg;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_COND = 2'b01,
      BR_CBZ  = 2'b10,
      BR_CBNZ = 2'b11
   } br_type_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational LEGv8 condition evaluator; shared by branches and conditional select.
module cond_eval
   import cpu_pkg::*;
(
   input  flags_t flags,
   input  cond_t  cond,
   output logic   cond_true
);

   always_comb begin
      cond_true = 1'b1;
      unique case (cond)
         COND_EQ: cond_true = flags.z;
         COND_NE: cond_true = ~flags.z;
         COND_HS: cond_true = flags.c;
         COND_LO: cond_true = ~flags.c;
         COND_MI: cond_true = flags.n;
         COND_PL: cond_true = ~flags.n;
         COND_VS: cond_true = flags.v;
         COND_VC: cond_true = ~flags.v;
         COND_HI: cond_true = flags.c & ~flags.z;
         COND_LS: cond_true = ~(flags.c & ~flags.z);
         COND_GE: cond_true = (flags.n == flags.v);
         COND_LT: cond_true = (flags.n != flags.v);
         COND_GT: cond_true = ~flags.z & (flags.n == flags.v);
         COND_LE: cond_true = ~(~flags.z & (flags.n == flags.v));
         COND_AL: cond_true = 1'b1;
         COND_NV: cond_true = 1'b1;
         default: cond_true = 1'b1;
      endcase
   end

endmodule

// File: rtl/flag_branch_unit.sv
// NZCV flag register with EX->ID flag bypass and ID-stage branch resolution.
module flag_branch_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter bit FORWARD = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic             ex_set_flags,
   input  logic             ex_negative,
   input  logic             ex_zero,
   input  logic             ex_overflow,
   input  logic             ex_carry,
   input  logic             ex_flush,
   input  logic             stall,
   input  logic             id_valid,
   input  logic [1:0]       id_br_type,
   input  logic [3:0]       id_cond,
   input  logic [WIDTH-1:0] id_reg_val,
   output logic             take_branch,
   output logic             flag_stall,
   output logic [3:0]       flags_q
);

   flags_t   flags_reg;
   flags_t   ex_flags;
   flags_t   eff_flags;
   logic     ex_wr;
   logic     cond_true;
   br_type_t br_type;

   assign ex_wr    = ex_valid & ex_set_flags & ~ex_flush;
   assign ex_flags = '{n: ex_negative, z: ex_zero, c: ex_carry, v: ex_overflow};
   assign br_type  = br_type_t'(id_br_type);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         flags_reg <= '0;
      else if (ex_wr & ~stall)
         flags_reg <= ex_flags;
   end

   assign flags_q = flags_reg;

   // The in-flight EX result wins over the stale register when bypass exists.
   assign eff_flags = (FORWARD && ex_wr) ? ex_flags : flags_reg;

   cond_eval u_cond_eval (
      .flags     (eff_flags),
      .cond      (cond_t'(id_cond)),
      .cond_true (cond_true)
   );

   always_comb begin
      flag_stall = 1'b0;
      if (!FORWARD)
         flag_stall = ~reset & ex_wr & id_valid & (br_type == BR_COND);
   end

   always_comb begin
      take_branch = 1'b0;
      if (~reset & id_valid & ~flag_stall) begin
         unique case (br_type)
            BR_COND: take_branch = cond_true;
            BR_CBZ:  take_branch = (id_reg_val == '0);
            BR_CBNZ: take_branch = (id_reg_val != '0);
            default: take_branch = 1'b0;
         endcase
      end
   end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer end of the 64-bit ALU's condition-flag interface (negative, zero, overflow, carry_out) in the 5-stage pipeline.
- Holds the architectural NZCV flag register, written by flag-setting instructions (ADDS/SUBS/ANDS) in EX.
- Forwards in-flight EX flags to the branch decision in ID.
- Resolves B.cond / CBZ / CBNZ in ID and raises a flag-hazard stall when forwarding is disabled.

Parameters:
WIDTH, 64, datapath width of the register value tested by CBZ/CBNZ
FORWARD, 1, 1 = EX flags bypass to ID; 0 = no bypass, assert flag_stall instead

Ports:
clk  input  1  pipeline clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears flag register
ex_valid  input  1  EX stage holds a live instruction
ex_set_flags  input  1  EX instruction writes NZCV
ex_negative  input  1  ALU negative flag
ex_zero  input  1  ALU zero flag
ex_overflow  input  1  ALU overflow flag
ex_carry  input  1  ALU carry_out (1 = no borrow on subtract)
ex_flush  input  1  EX instruction squashed this cycle
stall  input  1  pipeline frozen; no state update
id_valid  input  1  ID stage holds a live instruction
id_br_type  input  2  00 none, 01 B.cond, 10 CBZ, 11 CBNZ
id_cond  input  4  LEGv8 condition code for B.cond
id_reg_val  input  WIDTH  Rt value for CBZ/CBNZ (already forwarded)
take_branch  output  1  branch in ID is taken this cycle
flag_stall  output  1  ID must stall: needed flags not yet available
flags_q  output  4  architectural {N,Z,C,V}

Behaviour:
- Reset (async, any time): flags_q = 4'b0000. take_branch and flag_stall are forced 0 while reset is high.
- Flag write:
  - ex_wr = ex_valid & ex_set_flags & ~ex_flush.
  - On posedge, if ex_wr & ~stall, flags_q <= {ex_negative, ex_zero, ex_carry, ex_overflow}; otherwise hold.
  - Reset mid-cycle overrides any pending write.
- Effective flags for ID, combinational:
  - FORWARD=1 and ex_wr: use EX flags.
  - Otherwise: use flags_q.
- flag_stall = (FORWARD==0) & ex_wr & id_valid & (id_br_type==01). It is always 0 when FORWARD=1.
- Condition decode, using effective N,Z,C,V:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 HS: C. 3 LO: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !(C&!Z).
  - A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: !(!Z&(N==V)).
  - E, F AL: 1.
- take_branch = id_valid & ~flag_stall & one of:
  - br 01: cond_true.
  - br 10: id_reg_val == 0.
  - br 11: id_reg_val != 0.
  - br 00: 0.
- CBZ/CBNZ never read flags and never cause flag_stall.
- Latency: flags written in EX cycle n are visible in flags_q from cycle n+1. With FORWARD=1 they are also usable by ID in cycle n (0-cycle bypass).
- Simultaneous EX write and ID branch: the forwarded (new) value wins, never the stale flags_q.
- ex_flush with ex_set_flags: no write, no forward; ID sees flags_q.
- stall high: flags_q holds. take_branch is still evaluated combinationally; the pipeline ignores it.

Decomposition:
- Shared package cpu_pkg:
  - typedef br_type_t {BR_NONE, BR_COND, BR_CBZ, BR_CBNZ}.
  - enum cond_t with the 16 LEGv8 codes.
  - typedef flags_t packed struct {n, z, c, v}.
- Sub-module cond_eval: purely combinational, (flags_t, cond_t) -> cond_true. It is reused later by conditional-select.

Test Plan:
- Reset high mid-run after flags=1111 -> flags_q=0000 immediately (async), take_branch=0; release, B.EQ -> not taken.
- SUBS in EX (N0 Z1 C1 V0, ex_wr=1), B.EQ in ID same cycle, FORWARD=1 -> take_branch=1 that cycle; next cycle flags_q=0100... precisely {N,Z,C,V}=0110.
- Same as previous with FORWARD=0 -> flag_stall=1, take_branch=0; next cycle, EX idle -> flag_stall=0, take_branch=1.
- flags_q=1000 (N=1,V=0): B.LT -> 1, B.GE -> 0, B.GT -> 0, B.LE -> 1; flags_q=0010: B.HI -> 1, B.LS -> 0.
- ex_flush=1 with ex_set_flags (Z=1) over flags_q=0000, B.NE in ID -> taken; flags_q stays 0000.
- CBZ with id_reg_val=0 -> 1; CBZ with 64'h8000_0000_0000_0000 -> 0; CBNZ with the same value -> 1; flag_stall=0 throughout even when ex_wr=1 and FORWARD=0.
